// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the EX-stage multiply/divide unit.
//   md_op_e    - mult/div op encoding as decoded into the ID/EX register
//   md_state_e - sequencer states of ex_muldiv
//   md_cnt_w() - step counter width for a given iteration count
package muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } md_state_e;

  function automatic int unsigned md_cnt_w(input int unsigned steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

  localparam int unsigned MD_XLEN  = 32;
  localparam int unsigned MD_CNT_W = md_cnt_w(MD_XLEN);

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational radix-2 iteration on the {acc, q} pair.
//   i_is_div - 1: restoring-divide step, 0: shift-add multiply step
//   i_opnd   - multiplicand (multiply) or divisor (divide)
//   i_acc    - upper half: partial product / partial remainder
//   i_q      - lower half: multiplier bits / dividend bits, quotient shifts in
//   o_acc    - next upper half
//   o_q      - next lower half
module muldiv_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_is_div,
  input  logic [XLEN-1:0] i_opnd,
  input  logic [XLEN-1:0] i_acc,
  input  logic [XLEN-1:0] i_q,
  output logic [XLEN-1:0] o_acc,
  output logic [XLEN-1:0] o_q
);

  logic [XLEN:0] w_sum;
  logic [XLEN:0] w_rem;
  logic [XLEN:0] w_diff;
  logic          w_ge;

  always_comb begin
    // multiply: add multiplicand on q[0], then shift {carry, acc, q} right
    w_sum  = {1'b0, i_acc} + (i_q[0] ? {1'b0, i_opnd} : '0);
    // divide: shift next dividend bit into the partial remainder, try subtract
    w_rem  = {i_acc, i_q[XLEN-1]};
    w_diff = w_rem - {1'b0, i_opnd};
    w_ge   = (w_rem >= {1'b0, i_opnd});
    o_acc  = '0;
    o_q    = '0;
    if (i_is_div) begin
      o_acc = w_ge ? w_diff[XLEN-1:0] : w_rem[XLEN-1:0];
      o_q   = {i_q[XLEN-2:0], w_ge};
    end else begin
      o_acc = w_sum[XLEN:1];
      o_q   = {w_sum[0], i_q[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative multiply/divide unit in the EX stage, owning HI/LO.
//   clk, reset        - clock, synchronous active-high reset
//   start, op         - mult/div instruction valid in EX and its op
//   Rs_data, Rt_data  - operand A (multiplicand/dividend), B (multiplier/divisor)
//   mthi_we, mtlo_we  - MTHI/MTLO write enables, data on wdata
//   stall             - hold ID/EX and IF/ID (combinational)
//   busy, done        - registered: in CALC / one-cycle DONE pulse
//   hi, lo            - architectural HI/LO registers
module ex_muldiv
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned STEPS = XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] Rs_data,
  input  logic [XLEN-1:0] Rt_data,
  input  logic            mthi_we,
  input  logic            mtlo_we,
  input  logic [XLEN-1:0] wdata,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int unsigned      CNT_W = md_cnt_w(STEPS);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(STEPS - 1);

  md_state_e         r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_is_div;
  logic              r_neg_q;
  logic              r_neg_r;
  logic [XLEN-1:0]   r_opnd;
  logic [XLEN-1:0]   r_acc;
  logic [XLEN-1:0]   r_q;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic              r_busy;
  logic              r_done;

  md_op_e            w_op;
  logic              w_signed;
  logic              w_div;
  logic              w_a_neg;
  logic              w_b_neg;
  logic              w_div0;
  logic [XLEN-1:0]   w_a_abs;
  logic [XLEN-1:0]   w_b_abs;
  logic [XLEN-1:0]   w_acc_n;
  logic [XLEN-1:0]   w_q_n;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quot;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_res_hi;
  logic [XLEN-1:0]   w_res_lo;

  always_comb begin
    w_op     = md_op_e'(op);
    w_signed = (w_op == MD_MULT) || (w_op == MD_DIV);
    w_div    = (w_op == MD_DIV) || (w_op == MD_DIVU);
    w_a_neg  = w_signed & Rs_data[XLEN-1];
    w_b_neg  = w_signed & Rt_data[XLEN-1];
    w_a_abs  = w_a_neg ? -Rs_data : Rs_data;
    w_b_abs  = w_b_neg ? -Rt_data : Rt_data;
    w_div0   = w_div && (Rt_data == '0);
  end

  muldiv_step #(
    .XLEN(XLEN)
  ) u_step (
    .i_is_div(r_is_div),
    .i_opnd  (r_opnd),
    .i_acc   (r_acc),
    .i_q     (r_q),
    .o_acc   (w_acc_n),
    .o_q     (w_q_n)
  );

  // Sign fix-up of the final iteration's output, written to HI/LO at CALC exit.
  always_comb begin
    w_prod   = {w_acc_n, w_q_n};
    w_prod   = r_neg_q ? -w_prod : w_prod;
    w_quot   = r_neg_q ? -w_q_n : w_q_n;
    w_rem    = r_neg_r ? -w_acc_n : w_acc_n;
    w_res_hi = r_is_div ? w_rem  : w_prod[2*XLEN-1:XLEN];
    w_res_lo = r_is_div ? w_quot : w_prod[XLEN-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_q      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_is_div <= w_div;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_state  <= ST_CALC;
            r_busy   <= 1'b1;
            if (w_div0) begin
              // Unsigned divide of raw A by zero naturally yields q=all ones,
              // remainder=A; no sign fix-up so HI=A for signed ops too.
              r_opnd  <= '0;
              r_q     <= Rs_data;
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
            end else if (w_div) begin
              r_opnd  <= w_b_abs;
              r_q     <= w_a_abs;
              r_neg_q <= w_a_neg ^ w_b_neg;
              r_neg_r <= w_a_neg;
            end else begin
              r_opnd  <= w_a_abs;
              r_q     <= w_b_abs;
              r_neg_q <= w_a_neg ^ w_b_neg;
              r_neg_r <= 1'b0;
            end
          end else begin
            if (mthi_we) r_hi <= wdata;
            if (mtlo_we) r_lo <= wdata;
          end
        end
        ST_CALC: begin
          r_acc <= w_acc_n;
          r_q   <= w_q_n;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_hi    <= w_res_hi;
            r_lo    <= w_res_lo;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign stall = ((r_state == ST_IDLE) && start) || (r_state == ST_CALC);
  assign busy  = r_busy;
  assign done  = r_done;
  assign hi    = r_hi;
  assign lo    = r_lo;

endmodule
